// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM state and opcode constants shared by the ALU arbiter slice.
package alu_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2} state_t;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way arbiter, round-robin by default, fixed priority (r0 wins) when
// ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, advance};
    assign grant_id = !req[0] && req[1];
`else
    logic last_grant;
    always_ff @(posedge clk)
        if (rst) last_grant <= 1'b1;
        else if (advance) last_grant <= grant_id;
    assign grant_id = (req == 2'b11) ? !last_grant : req[1];
`endif
    assign grant = {req[1] && grant_id, req[0] && !grant_id};
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered alu between two valid/ready requesters.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority in rr_arb2.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req_valid,
    output logic         r0_req_ready,
    input  logic [n-1:0] r0_a,
    input  logic [n-1:0] r0_b,
    input  logic [2:0]   r0_op,
    output logic         r0_resp_valid,
    input  logic         r0_resp_ready,
    input  logic         r1_req_valid,
    output logic         r1_req_ready,
    input  logic [n-1:0] r1_a,
    input  logic [n-1:0] r1_b,
    input  logic [2:0]   r1_op,
    output logic         r1_resp_valid,
    input  logic         r1_resp_ready,
    output logic [n-1:0] resp_sum,
    output logic         resp_o,
    output logic         resp_z,
    output logic         resp_n,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_en,
    input  logic [n-1:0] alu_sum,
    input  logic         alu_o,
    input  logic         alu_z,
    input  logic         alu_n
);
    state_t state;
    logic [n-1:0] a_q, b_q;
    logic [2:0] op_q;
    logic id_q, idle, hs, grant_id;
    logic [1:0] grant;
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({r1_req_valid, r0_req_valid}),
        .advance  (hs),
        .grant    (grant),
        .grant_id (grant_id)
    );
    // ready is masked during reset so no command slips in while rst is held
    assign idle = (state == ST_IDLE) && !rst;
    assign hs = idle && |grant;
    assign r0_req_ready = idle && grant[0];
    assign r1_req_ready = idle && grant[1];
    always_ff @(posedge clk)
        if (rst) begin
            state <= ST_IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (hs) begin
                        a_q <= grant_id ? r1_a : r0_a;
                        b_q <= grant_id ? r1_b : r0_b;
                        op_q <= grant_id ? r1_op : r0_op;
                        id_q <= grant_id;
                        state <= ST_ISSUE;
                    end
                ST_ISSUE: state <= ST_RESP;
                ST_RESP: if (id_q ? r1_resp_ready : r0_resp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    assign alu_en = state == ST_ISSUE;
    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_op = op_q;
    assign r0_resp_valid = (state == ST_RESP) && !id_q;
    assign r1_resp_valid = (state == ST_RESP) && id_q;
    assign resp_sum = alu_sum;
    assign resp_o = alu_o;
    assign resp_z = alu_z;
    assign resp_n = alu_n;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural alu.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r0_req_valid = 1'b0, r0_req_ready, r0_resp_valid, r0_resp_ready = 1'b1;
    logic r1_req_valid = 1'b0, r1_req_ready, r1_resp_valid, r1_resp_ready = 1'b1;
    logic [7:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [2:0] r0_op = '0, r1_op = '0;
    logic [7:0] resp_sum, alu_a, alu_b, alu_sum, s_nx;
    logic resp_o, resp_z, resp_n, alu_en, alu_o, alu_z, alu_n, o_nx;
    logic [2:0] alu_op;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.n(8)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
        .resp_sum(resp_sum), .resp_o(resp_o), .resp_z(resp_z), .resp_n(resp_n),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_sum(alu_sum), .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n)
    );

    // registered alu: op 0 add, op 1 sub, others and
    always_comb begin
        s_nx = alu_op == 3'd0 ? alu_a + alu_b : alu_op == 3'd1 ? alu_a - alu_b : alu_a & alu_b;
        o_nx = alu_op == 3'd0 ? (alu_a[7] == alu_b[7]) && (s_nx[7] != alu_a[7]) :
               alu_op == 3'd1 ? (alu_a[7] != alu_b[7]) && (s_nx[7] != alu_a[7]) : 1'b0;
    end
    always_ff @(posedge clk)
        if (rst) begin
            alu_sum <= '0;
            alu_o <= 1'b0;
            alu_z <= 1'b0;
            alu_n <= 1'b0;
        end else if (alu_en) begin
            alu_sum <= s_nx;
            alu_o <= o_nx;
            alu_z <= s_nx == 8'h00;
            alu_n <= s_nx[7];
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        r0_req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if ({r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid, alu_en} !== 5'b0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %b, want 00000", i,
                         {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid, alu_en});
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (r0_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_idle_ready: got %b, want 1", r0_req_ready);
        end
        r0_req_valid = 1'b0;
    endtask

    task automatic test_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [7:0] es, input logic [2:0] eozn,
                           input string name);
        int t;
        r0_resp_ready = 1'b1;
        r1_resp_ready = 1'b1;
        if (id) begin r1_req_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
        else begin r0_req_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
        #1;
        t = 0;
        while (!(id ? r1_req_ready : r0_req_ready) && t < 20) begin
            tick;
            t++;
        end
        checks++;
        if (t == 20) begin
            fails++;
            $display("FAIL %s_handshake: ready not seen within %0d cycles", name, t);
        end
        tick;
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        checks++;
        if ({alu_en, alu_a, alu_b, alu_op} !== {1'b1, a, b, op}) begin
            fails++;
            $display("FAIL %s_issue: got en=%b a=%h b=%h op=%0d, want en=1 a=%h b=%h op=%0d",
                     name, alu_en, alu_a, alu_b, alu_op, a, b, op);
        end
        tick;
        checks++;
        if ({alu_en, r0_resp_valid, r1_resp_valid} !== {1'b0, !id, id}) begin
            fails++;
            $display("FAIL %s_resp_valid: got en=%b v0=%b v1=%b, want en=0 v0=%b v1=%b",
                     name, alu_en, r0_resp_valid, r1_resp_valid, !id, id);
        end
        checks++;
        if ({resp_sum, resp_o, resp_z, resp_n} !== {es, eozn}) begin
            fails++;
            $display("FAIL %s_result: got sum=%h ozn=%b, want sum=%h ozn=%b",
                     name, resp_sum, {resp_o, resp_z, resp_n}, es, eozn);
        end
        tick;
        checks++;
        if ({r0_resp_valid, r1_resp_valid} !== 2'b00) begin
            fails++;
            $display("FAIL %s_resp_done: got %b, want 00", name, {r0_resp_valid, r1_resp_valid});
        end
    endtask

    task automatic test_contention;
        logic eid;
        r0_resp_ready = 1'b1;
        r1_resp_ready = 1'b1;
        r0_req_valid = 1'b1; r0_a = 8'h01; r0_b = 8'h02; r0_op = 3'd0;
        r1_req_valid = 1'b1; r1_a = 8'h10; r1_b = 8'h20; r1_op = 3'd0;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            eid = 1'b0;
`else
            eid = k[0];
`endif
            checks++;
            if ({r1_req_ready, r0_req_ready} !== {eid, !eid}) begin
                fails++;
                $display("FAIL contention_grant %0d: got ready=%b, want %b", k,
                         {r1_req_ready, r0_req_ready}, {eid, !eid});
            end
            tick;
            checks++;
            if ({r1_req_ready, r0_req_ready} !== 2'b00) begin
                fails++;
                $display("FAIL contention_busy_ready %0d: got %b, want 00", k, {r1_req_ready, r0_req_ready});
            end
            tick;
            checks++;
            if ({r1_resp_valid, r0_resp_valid, resp_sum} !== {eid, !eid, eid ? 8'h30 : 8'h03}) begin
                fails++;
                $display("FAIL contention_resp %0d: got v=%b sum=%h, want v=%b sum=%h", k,
                         {r1_resp_valid, r0_resp_valid}, resp_sum, {eid, !eid}, eid ? 8'h30 : 8'h03);
            end
            tick;
        end
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        r0_resp_ready = 1'b0;
        r1_resp_ready = 1'b1;
        r0_req_valid = 1'b1; r0_a = 8'h05; r0_b = 8'h03; r0_op = 3'd0;
        #1;
        checks++;
        if (r0_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_r0_ready: got %b, want 1", r0_req_ready);
        end
        tick;
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b1; r1_a = 8'h10; r1_b = 8'h01; r1_op = 3'd1;
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({r0_resp_valid, r1_resp_valid, r1_req_ready, resp_sum} !== {3'b100, 8'h08}) begin
                fails++;
                $display("FAIL bp_hold %0d: got v0=%b v1=%b r1rdy=%b sum=%h, want 1 0 0 08", i,
                         r0_resp_valid, r1_resp_valid, r1_req_ready, resp_sum);
            end
            tick;
        end
        r0_resp_ready = 1'b1;
        tick;
        checks++;
        if ({r0_resp_valid, r1_req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: got v0=%b r1rdy=%b, want 0 1", r0_resp_valid, r1_req_ready);
        end
        tick;
        r1_req_valid = 1'b0;
        tick;
        checks++;
        if ({r1_resp_valid, r0_resp_valid, resp_sum, resp_o, resp_z, resp_n} !== {2'b10, 8'h0F, 3'b000}) begin
            fails++;
            $display("FAIL bp_r1_resp: got v=%b sum=%h ozn=%b, want 10 0f 000",
                     {r1_resp_valid, r0_resp_valid}, resp_sum, {resp_o, resp_z, resp_n});
        end
        tick;
    endtask

    task automatic test_reset_in_resp;
        r0_resp_ready = 1'b0;
        r0_req_valid = 1'b1; r0_a = 8'h02; r0_b = 8'h02; r0_op = 3'd0;
        #1;
        tick;
        r0_req_valid = 1'b0;
        tick;
        checks++;
        if (r0_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL rstresp_pre: got %b, want 1", r0_resp_valid);
        end
        rst = 1'b1;
        tick;
        checks++;
        if ({r0_resp_valid, r1_resp_valid, alu_en} !== 3'b000) begin
            fails++;
            $display("FAIL rstresp_drop: got %b, want 000", {r0_resp_valid, r1_resp_valid, alu_en});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({r0_resp_valid, r1_resp_valid, alu_en} !== 3'b000) begin
                fails++;
                $display("FAIL rstresp_stale %0d: got %b, want 000", i, {r0_resp_valid, r1_resp_valid, alu_en});
            end
        end
        r0_resp_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_contention;
        test_op(1'b0, 8'h01, 8'h89, 3'd0, 8'h8A, 3'b001, "add_r0");
        test_op(1'b1, 8'h41, 8'h41, 3'd0, 8'h82, 3'b101, "ovf_r1");
        test_op(1'b0, 8'h01, 8'h01, 3'd1, 8'h00, 3'b010, "zero_r0");
        test_backpressure;
        test_reset_in_resp;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered `alu` instance between two requesters.
- Each requester has a valid/ready command channel (A, B, op) and a valid/ready response channel (result plus o/z/n flags).
- The arbiter does round-robin selection, sequences the ALU enable, and routes the held ALU result back to the granted requester.
- Sits between the requesters and the `alu` datapath; the `alu` shares `clk`/`rst` with this block.

Parameters:
- n, 8, operand/result width; must match the attached `alu` instance.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- r0_req_valid  in  1  requester 0 command valid
- r0_req_ready  out  1  requester 0 command accepted
- r0_a, r0_b  in  n each  requester 0 operands
- r0_op  in  3  requester 0 ALU opcode (0 add, 1 sub, 2..7 per alu encoding)
- r0_resp_valid  out  1  requester 0 response valid
- r0_resp_ready  in  1  requester 0 response consumed
- r1_*  same set as r0_* for requester 1
- resp_sum  out  n  result, shared by both response channels
- resp_o, resp_z, resp_n  out  1 each  flags, shared by both response channels
- alu_a, alu_b  out  n each  to alu A, B
- alu_op  out  3  to alu op
- alu_en  out  1  to alu en
- alu_sum  in  n  from alu sum
- alu_o, alu_z, alu_n  in  1 each  from alu o_flag, z_flag, n_flag

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high (`rst`).
- ALU contract: when alu_en=1 at edge k, alu_sum and flags are updated and valid after edge k; they hold while alu_en=0.
- FSM states IDLE, ISSUE, RESP; 2-bit encoding.
- IDLE:
  - rX_req_ready=1 only for the requester chosen by arbitration, and only when it asserts valid.
  - On a handshake: latch a, b, op and the 1-bit grant id into operand registers; go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - alu_en=1 and alu_a/b/op driven from the latched registers; all other cycles alu_en=0.
  - Go to RESP.
- RESP:
  - r[id]_resp_valid=1; resp_sum/flags driven from the alu_* inputs.
  - Hold until r[id]_resp_ready=1, then go to IDLE.
  - The other requester's resp_valid stays 0.
- Latency: handshake at cycle T; alu_en at T+1; resp_valid from T+2. Minimum issue interval is 3 cycles, because IDLE is re-entered at T+3.
- Arbitration is round-robin:
  - last_grant register, reset to 1, so requester 0 wins the first contention.
  - Both requesting: grant !last_grant. Only one requesting: grant it.
  - last_grant updates only on a handshake.
- Request valid/ready rules:
  - A requester keeps valid and data stable until ready.
  - A request deasserted before grant is simply not served.
  - Inputs arriving during ISSUE/RESP are ignored; ready is 0 outside IDLE.
- Response shared-data rule: resp_sum/flags are meaningful only while the corresponding resp_valid=1. In IDLE they are driven from alu_* and are don't-care.
- Reset values:
  - state=IDLE, last_grant=1, operand registers=0, id=0.
  - All ready/valid outputs=0, alu_en=0, alu_a/b/op=0.
- Reset mid-operation: the in-flight command or response is dropped with no response issued; the next cycle is IDLE.
- Widths: no arithmetic in this block; operands pass through unmodified at n bits.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority; requester 0 always wins contention, and last_grant is removed.
- Undefined: round-robin as above.

Decomposition:
- Package/header alu_arb_pkg: FSM state constants (ST_IDLE=0, ST_ISSUE=1, ST_RESP=2) and opcode constants (OP_ADD=0, OP_SUB=1).
- Sub-module rr_arb2: 2-way arbiter.
  - Inputs: req[1:0], advance, clk, rst.
  - Outputs: one-hot grant and grant id.
  - Holds last_grant, and contains the ALU_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Reset: rst=1 for 2 cycles with r0_req_valid=1 → all ready/valid/alu_en=0; after release, r0_req_ready=1 in the first IDLE cycle.
- Single add, r0: a=0x01, b=0x89, op=0, resp_ready=1 → alu_en exactly 1 cycle at T+1; r0_resp_valid at T+2 with resp_sum=0x8A, n=1, z=0, o=0; r1_resp_valid=0.
- Overflow via r1: a=0x41, b=0x41, op=0 → resp_sum=0x82, o=1, n=1.
- Zero via r0: a=0x01, b=0x01, op=1 → resp_sum=0x00, z=1.
- Contention, both valid continuously for 4 commands → grants in order r0, r1, r0, r1 (with macro: r0, r0, r0, r0). Each response is routed to its own requester.
- Backpressure: r0_resp_ready=0 for 5 cycles → resp_valid and resp_sum held stable; r1 request not accepted until the r0 response handshake completes.
- Reset during RESP → resp_valid drops the next cycle; no stale response after reset.
